// File: rtl/ram_byte_master_if.sv
// Pipeline-side request/response bus plus the byte-wide RAM bus of ram_byte_master.
// When RAM_BYTE_MASTER_SIGNEXT_EN is defined, the interface also carries req_signed.
interface ram_byte_master_if #(
    parameter int unsigned ADDR_W = 19
);
    // Pipeline request
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
    logic              req_signed;
`endif
    // Pipeline response
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic              stall;
    // Byte-wide RAM
    logic [ADDR_W-1:0] A;
    logic [7:0]        D;
    logic              RD;
    logic              WR;
    logic [7:0]        S;

    modport master (
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        input  req_signed,
`endif
        input  req_valid, req_we, req_size, req_addr, req_wdata, S,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, stall, A, D, RD, WR
    );

    modport slave (
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        output req_signed,
`endif
        output req_valid, req_we, req_size, req_addr, req_wdata, S,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, stall, A, D, RD, WR
    );
endinterface

// File: rtl/ram_byte_master.sv
// Byte-wide RAM initiator: turns one byte/half/word load or store from the MEM stage
// into single-byte RAM beats and returns a 32-bit response with a stall indication.
// Optional feature macro: RAM_BYTE_MASTER_SIGNEXT_EN (sign-extended byte/half loads).
module ram_byte_master #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned RD_LAT = 1
) (
    input logic               CLK,
    input logic               RST,
    ram_byte_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StWbeat, StRbeat, StDone} state_e;

    localparam logic [2:0]        LatMax  = 3'(RD_LAT);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] a_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_q;     // index of the final beat: 0, 1 or 3
    logic [2:0]        lat_q;      // cycle within a read beat
    logic              err_q;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
    logic              signed_q;
`endif

    logic              accept;
    logic              req_err;
    logic [1:0]        req_last;

    assign accept = (state_q == StIdle) && bus.req_valid;

    // Decode size/alignment of the request currently presented
    always_comb begin
        req_err  = 1'b0;
        req_last = 2'd0;
        unique case (bus.req_size)
            2'b00: req_last = 2'd0;
            2'b01: begin
                req_last = 2'd1;
                req_err  = bus.req_addr[0];
            end
            2'b10: begin
                req_last = 2'd3;
                req_err  = |bus.req_addr[1:0];
            end
            default: req_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = StDone;
                    end else if (bus.req_we) begin
                        state_d = StWbeat;
                    end else begin
                        state_d = StRbeat;
                    end
                end
            end
            StWbeat: begin
                if (beat_q == last_q) begin
                    state_d = StDone;
                end
            end
            StRbeat: begin
                if ((lat_q == LatMax) && (beat_q == last_q)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latch, beat/latency counters, address stepping and read-data capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q      <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            beat_q   <= '0;
            last_q   <= '0;
            lat_q    <= '0;
            err_q    <= 1'b0;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
            signed_q <= 1'b0;
`endif
        end else if (accept) begin
            // A keeps its last value on an error since no beat is issued
            if (!req_err) begin
                a_q <= bus.req_addr;
            end
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
            beat_q   <= '0;
            last_q   <= req_last;
            lat_q    <= '0;
            err_q    <= req_err;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
            signed_q <= bus.req_signed;
`endif
        end else if (state_q == StWbeat) begin
            if (beat_q != last_q) begin
                beat_q <= beat_q + 2'd1;
                a_q    <= a_q + AddrOne;
            end
        end else if (state_q == StRbeat) begin
            if (lat_q == LatMax) begin
                lat_q                        <= '0;
                rdata_q[{beat_q, 3'b000} +: 8] <= bus.S;
                if (beat_q != last_q) begin
                    beat_q <= beat_q + 2'd1;
                    a_q    <= a_q + AddrOne;
                end
            end else begin
                lat_q <= lat_q + 3'd1;
            end
        end
    end

    // Outputs decoded from state and the latched request
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StDone);
        bus.stall     = ((state_q == StIdle) && bus.req_valid) ||
                        (state_q == StWbeat) || (state_q == StRbeat);
        bus.rsp_err   = err_q;
        bus.A         = a_q;
        bus.WR        = (state_q == StWbeat);
        bus.RD        = (state_q == StRbeat);
        bus.D         = (state_q == StWbeat) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
        // Upper bytes of rdata_q stay zero for byte/half loads, stores and errors
        bus.rsp_rdata = rdata_q;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        if (signed_q) begin
            if (last_q == 2'd0) begin
                bus.rsp_rdata = {{24{rdata_q[7]}}, rdata_q[7:0]};
            end else if (last_q == 2'd1) begin
                bus.rsp_rdata = {{16{rdata_q[15]}}, rdata_q[15:0]};
            end
        end
`endif
    end

endmodule

// File: tb/tb_ram_byte_master.sv
// Self-checking bench for ram_byte_master: a behavioural RAM device, a reference byte
// memory and expected responses computed from access size, alignment and latency rules.
module tb_ram_byte_master;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    ram_byte_master_if #(.ADDR_W(ADDR_W)) bus ();

    ram_byte_master #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ------------------------------------------------------------------ RAM device
    logic [7:0] ram     [MEM_SZ];
    logic [7:0] ref_mem [MEM_SZ];
    logic [7:0] pipe_d  [RD_LAT];
    bit         pipe_v  [RD_LAT];
    bit         ram_init = 1'b0;
    logic [7:0] junk = 8'h00;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ (i >> 7));
    endfunction

    // Write port, plus read pipeline: RD sampled at an edge gives valid S RD_LAT edges later
    always @(posedge CLK) begin
        if (!ram_init) begin
            for (int i = 0; i < int'(MEM_SZ); i++) ram[i] <= init_byte(i);
            ram_init <= 1'b1;
        end else if (bus.WR) begin
            ram[bus.A] <= bus.D;
        end
        pipe_v[0] <= bus.RD;
        pipe_d[0] <= ram[bus.A];
        for (int k = 1; k < int'(RD_LAT); k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end

    // Garbage on S whenever no read result is due, so mistimed captures show up
    always @(negedge CLK) junk <= 8'($urandom);

    assign bus.S = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

    // ------------------------------------------------------------------ checking
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request queued behind the current one when req_valid is held high
    logic              nx_we;
    logic [1:0]        nx_size;
    logic [ADDR_W-1:0] nx_addr;
    logic [31:0]       nx_wdata;

    task automatic drive_post(input bit chain);
        if (chain) begin
            bus.req_valid = 1'b1;
            bus.req_we    = nx_we;
            bus.req_size  = nx_size;
            bus.req_addr  = nx_addr;
            bus.req_wdata = nx_wdata;
        end else begin
            // Scrambled inputs after the accept edge must have no effect
            bus.req_valid = 1'b0;
            bus.req_we    = 1'($urandom);
            bus.req_size  = 2'($urandom);
            bus.req_addr  = ADDR_W'($urandom);
            bus.req_wdata = $urandom;
        end
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        bus.req_signed = 1'($urandom);
`endif
    endtask

    task automatic run_req(input logic we, input logic [1:0] size,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                           input logic sgn, input bit chain, input string tag);
        int                n, exp_lat, lat, rd_cnt, wr_cnt, stall_cnt, exp_rd_cnt, exp_wr_cnt;
        bit                err, both, ready_busy, got_rsp;
        logic [31:0]       exp_rd, dev_word, ref_word;
        logic [ADDR_W-1:0] a0, exp_a;

        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        bus.req_signed = sgn;
`endif
        #1;
        chk({tag, " ready@0"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " stall@0"}, 32'(bus.stall), 32'd1);
        a0 = bus.A;

        // Reference model
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        err = (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
              ((size == 2'd2) && (addr[1:0] != 2'd0));
        exp_rd = 32'h0;
        if (!err && we) begin
            for (int i = 0; i < n; i++) ref_mem[ADDR_W'(int'(addr) + i)] = wdata[8*i +: 8];
        end
        if (!err && !we) begin
            for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[ADDR_W'(int'(addr) + i)];
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
            if (sgn && (n == 1)) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
            if (sgn && (n == 2)) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
`else
            exp_rd = sgn ? exp_rd : exp_rd;  // signedness has no effect without the feature
`endif
        end
        exp_lat    = err ? 1 : we ? n + 1 : n * (int'(RD_LAT) + 1) + 1;
        exp_a      = err ? a0 : ADDR_W'(int'(addr) + n - 1);
        exp_wr_cnt = (!err && we) ? n : 0;
        exp_rd_cnt = (!err && !we) ? n * (int'(RD_LAT) + 1) : 0;

        lat = 0; rd_cnt = 0; wr_cnt = 0; stall_cnt = 1;
        both = 1'b0; ready_busy = 1'b0;
        while (1) begin
            @(negedge CLK);
            lat++;
            got_rsp = bus.rsp_valid;
            if (!got_rsp) begin
                rd_cnt     += int'(bus.RD);
                wr_cnt     += int'(bus.WR);
                stall_cnt  += int'(bus.stall);
                both       |= bus.RD & bus.WR;
                ready_busy |= bus.req_ready;
            end
            if (lat == 1) drive_post(chain);
            if (got_rsp || lat > 64) break;
        end

        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(err));
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, " stall@rsp"}, 32'(bus.stall), 32'd0);
        chk({tag, " ready@rsp"}, 32'(bus.req_ready), 32'd0);
        chk({tag, " strobes@rsp"}, {30'd0, bus.RD, bus.WR}, 32'd0);
        chk({tag, " D@rsp"}, 32'(bus.D), 32'd0);
        chk({tag, " A@rsp"}, 32'(bus.A), 32'(exp_a));
        chk({tag, " WR cycles"}, 32'(wr_cnt), 32'(exp_wr_cnt));
        chk({tag, " RD cycles"}, 32'(rd_cnt), 32'(exp_rd_cnt));
        chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
        chk({tag, " RD&WR"}, 32'(both), 32'd0);
        chk({tag, " ready busy"}, 32'(ready_busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            dev_word[8*k +: 8] = ram[ADDR_W'(int'(addr) + k)];
            ref_word[8*k +: 8] = ref_mem[ADDR_W'(int'(addr) + k)];
        end
        chk({tag, " ram contents"}, dev_word, ref_word);
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        logic              r_we, r_sgn;
        logic [1:0]        r_size;
        logic [ADDR_W-1:0] r_addr;
        bit                saw_rsp;

        for (int i = 0; i < int'(MEM_SZ); i++) ref_mem[i] = init_byte(i);
        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'h0;
`ifdef RAM_BYTE_MASTER_SIGNEXT_EN
        bus.req_signed = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        chk("reset A", 32'(bus.A), 32'd0);
        chk("reset D", 32'(bus.D), 32'd0);
        chk("reset strobes", {30'd0, bus.RD, bus.WR}, 32'd0);
        chk("reset ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.stall}, 32'd0);
        chk("reset rdata", bus.rsp_rdata, 32'd0);
        RST = 1'b0;

        // Directed accesses
        run_req(1'b1, 2'd2, 19'h00010, 32'hDEADBEEF, 1'b0, 1'b0, "st word");
        chk("st word bytes", {ram[19'h13], ram[19'h12], ram[19'h11], ram[19'h10]}, 32'hDEADBEEF);
        run_req(1'b0, 2'd2, 19'h00010, 32'h0, 1'b0, 1'b0, "ld word");
        run_req(1'b1, 2'd0, 19'h15762, 32'hA5A5A580, 1'b0, 1'b0, "st byte");
        run_req(1'b0, 2'd0, 19'h15762, 32'h0, 1'b0, 1'b0, "ld byte u");
        run_req(1'b0, 2'd0, 19'h15762, 32'h0, 1'b1, 1'b0, "ld byte s");
        run_req(1'b0, 2'd1, 19'h00012, 32'h0, 1'b1, 1'b0, "ld half s");
        run_req(1'b1, 2'd2, 19'h00002, 32'h01234567, 1'b0, 1'b0, "st misalign");
        run_req(1'b0, 2'd1, 19'h00001, 32'h0, 1'b0, 1'b0, "ld misalign");
        run_req(1'b0, 2'd3, 19'h00020, 32'h0, 1'b0, 1'b0, "reserved size");

        // Reset in cycle 3 of a word load abandons it
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 19'h00010;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst A", 32'(bus.A), 32'd0);
        chk("midrst D", 32'(bus.D), 32'd0);
        chk("midrst strobes", {30'd0, bus.RD, bus.WR}, 32'd0);
        chk("midrst ready", 32'(bus.req_ready), 32'd1);
        chk("midrst rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.stall}, 32'd0);
        chk("midrst rdata", bus.rsp_rdata, 32'd0);
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 1) RST = 1'b0;
            saw_rsp |= bus.rsp_valid;
        end
        chk("midrst no rsp", 32'(saw_rsp), 32'd0);
        run_req(1'b0, 2'd0, 19'h7FFFF, 32'h0, 1'b0, 1'b0, "ld top byte");

        // req_valid held high across two word stores
        nx_we    = 1'b1;
        nx_size  = 2'd2;
        nx_addr  = 19'h00024;
        nx_wdata = 32'h12345678;
        run_req(1'b1, 2'd2, 19'h00020, 32'hCAFEF00D, 1'b0, 1'b1, "b2b first");
        run_req(nx_we, nx_size, nx_addr, nx_wdata, 1'b0, 1'b0, "b2b second");

        // Randomized accesses, mostly aligned and often in a small window so loads see stores
        for (int t = 0; t < 40; t++) begin
            r_we   = 1'($urandom);
            r_sgn  = 1'($urandom);
            r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 63))
                                                 : ADDR_W'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'd1) r_addr[0] = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'd0;
            end
            run_req(r_we, r_size, r_addr, $urandom, r_sgn, 1'b0, "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_byte_master.md
Name: ram_byte_master

Overview:
- Initiator side of the byte-wide data RAM interface (A[18:0], D[7:0], RD, WR, S[7:0]).
- Sits between the pipeline MEM stage and the RAM.
- Converts one byte, half or word load/store request into a sequence of single-byte RAM beats.
- Returns a 32-bit response and a stall indication to the pipeline.

Parameters:
- ADDR_W, 19, RAM byte-address width.
- RD_LAT, 1, cycles from the edge where the RAM samples RD=1 to the edge where S is valid for capture (range 1..4).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  master can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, little-endian; low bytes used for byte/half.
- rsp_valid  out  1  one-cycle pulse; access complete.
- rsp_err  out  1  qualified by rsp_valid; misaligned or reserved size.
- rsp_rdata  out  32  load result, qualified by rsp_valid; 0 for stores and errors.
- stall  out  1  high from the accept cycle through the cycle before rsp_valid.
- A  out  ADDR_W  RAM byte address.
- D  out  8  RAM write data.
- RD  out  1  RAM read strobe.
- WR  out  1  RAM write strobe.
- S  in  8  RAM read data.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - A = 0, D = 0, RD = 0, WR = 0.
  - req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, stall = 0.
  - Reset mid-access abandons the access; no rsp_valid is ever produced for it.
- States: IDLE, WBEAT, RBEAT, DONE.
- Accept: a request is accepted on the rising edge where req_valid=1 in IDLE. req_addr, req_size, req_we and req_wdata are latched on that edge.
- Beat count N = 1, 2 or 4 for size 00, 01, 10.
- Error case: size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - Go IDLE→DONE with rsp_err=1 and rsp_rdata=0.
  - RD and WR never assert.
- Store:
  - IDLE→WBEAT. Beat i lasts exactly 1 cycle: A = base+i, D = wdata[8i+7:8i], WR = 1, RD = 0.
  - After beat N−1 → DONE.
- Load:
  - IDLE→RBEAT. Beat i lasts RD_LAT+1 cycles. A = base+i and RD = 1 are held for the whole beat; WR = 0.
  - S is captured into rdata[8i+7:8i] on the final edge of the beat.
  - After beat N−1 → DONE.
  - Unused upper bytes are zero-extended unless the optional feature is enabled.
- DONE:
  - Lasts 1 cycle. rsp_valid = 1, stall = 0, req_ready = 0.
  - Next state is IDLE. rsp_rdata and rsp_err hold their values until the next accept.
- Latency (accept cycle = cycle 0):
  - Store: N beat cycles, rsp_valid in cycle N+1.
  - Load: N·(RD_LAT+1) beat cycles, rsp_valid in cycle N·(RD_LAT+1)+1.
  - Error: rsp_valid in cycle 1.
- Outside beats: A holds its last value, D = 0, RD = 0, WR = 0. RD and WR are never high together.
- Alignment: aligned accesses never cross the 2^ADDR_W boundary. A is computed as base+i in ADDR_W bits, with no carry out.
- Busy: req_valid held high while busy is ignored (req_ready = 0). It is accepted in the first following IDLE cycle; back-to-back issue rate is one request per rsp + 1 cycle.
- Inputs while busy: changes to the req_* inputs after the accept edge have no effect.

Optional Feature:
- Macro: RAM_BYTE_MASTER_SIGNEXT_EN.
- Defined:
  - Adds input port req_signed (1 bit), latched at accept.
  - For byte/half loads with req_signed = 1, rsp_rdata is sign-extended from bit 7 or bit 15.
  - req_signed = 0 gives zero-extension.
- Undefined:
  - Port req_signed is absent.
  - All byte/half loads are zero-extended.

Test Plan:
- Store word 0xDEADBEEF to 0x00010, RD_LAT = 1 → WR beats in cycles 1–4 with A = 0x00010..0x00013 and D = EF, BE, AD, DE; rsp_valid in cycle 5 with err = 0 and rdata = 0; stall high in cycles 0–4.
- Load word from 0x00010 after the store above → RD held 2 cycles per beat; rsp_valid in cycle 9 with rsp_rdata = 0xDEADBEEF; WR stays 0.
- Byte load from 0x15762 holding 0x80 → rsp_rdata = 0x00000080. With the macro defined and req_signed = 1, rsp_rdata = 0xFFFFFF80.
- Misaligned requests:
  - Word store at 0x00002 → rsp_valid in cycle 1 with rsp_err = 1; no RD or WR pulse; RAM contents unchanged.
  - Half load at 0x00001 → same error response; no RD or WR pulse.
- Assert RST during cycle 3 of a word load → all outputs return to reset values immediately, no rsp_valid; a new byte load at 0x7FFFF completes normally with A = 0x7FFFF.
- req_valid held high across two consecutive word stores → second request accepted in the cycle after the first rsp_valid; req_ready = 0 throughout the first access.
